alu_issue: RTL

Upstream issue stage for the combinational `alu`. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. Each request drives the ALU operand and opcode inputs for a fixed settle window, which is longer for multiply. It then captures the 2N-bit result, computes the three status flags the ALU does not yet produce, and presents result plus flags on a valid/ready response port.

---
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_issue.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signals of the alu_issue stage.
// The slave modport is the issue stage; the master is its environment.
interface alu_issue_if #(
    parameter int unsigned N = 32
);
    logic           req_valid;
    logic           req_ready;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic [2:0]     req_op;
    logic           alu_en;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [2*N-1:0] alu_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_y;
    logic [2:0]     rsp_flag;
    logic           busy;

    modport master (
        output req_valid, req_a, req_b, req_op, alu_y, rsp_ready,
        input  req_ready, alu_en, alu_a, alu_b, alu_op,
               rsp_valid, rsp_y, rsp_flag, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_y, rsp_ready,
        output req_ready, alu_en, alu_a, alu_b, alu_op,
               rsp_valid, rsp_y, rsp_flag, busy
    );
endinterface

// File: rtl/alu_issue.sv
// Issue stage for a combinational ALU: queues requests, drives the ALU for a
// per-op settle window, then holds result plus {H,N,Z} flags on a response port.
module alu_issue #(
    parameter int unsigned N       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_issue_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int unsigned EW = 2 * N + 3;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t          state_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            alu_en_q;
    logic [N-1:0]    alu_a_q, alu_b_q;
    logic [2:0]      alu_op_q;
    logic            rsp_valid_q;
    logic [2*N-1:0]  rsp_y_q;
    logic [2:0]      rsp_flag_q;

    logic            full, empty, push, pop;
    logic [N-1:0]    head_a, head_b;
    logic [2:0]      head_op;
    logic [2:0]      flag_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Ready is forced low while reset is held so every output reads zero.
    assign bus.req_ready = rst_n && !full;
    assign push = bus.req_valid && bus.req_ready;
    assign pop  = (state_q == IDLE) && !empty;

    assign {head_a, head_b, head_op} = mem_q[rd_ptr_q[AW-1:0]];
    assign flag_d = {|bus.alu_y[2*N-1:N], bus.alu_y[N-1], (bus.alu_y == '0)};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.req_a, bus.req_b, bus.req_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            alu_en_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flag_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                        alu_a_q  <= head_a;
                        alu_b_q  <= head_b;
                        alu_op_q <= head_op;
                        alu_en_q <= 1'b1;
                        cnt_q    <= (head_op == 3'b111) ? CW'(MUL_LAT - 1) : '0;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        rsp_y_q     <= bus.alu_y;
                        rsp_flag_q  <= flag_d;
                        rsp_valid_q <= 1'b1;
                        alu_en_q    <= 1'b0;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_en    = alu_en_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_flag  = rsp_flag_q;
    assign bus.busy      = !empty || (state_q != IDLE);
endmodule
